// File: rtl/round_latency_tracker_if.sv
// Handshake bundle between the round controller / decoder environment
// (master) and the round latency tracker (slave).
interface round_latency_tracker_if #(
  parameter int DURATION_WIDTH = 32
);
  logic                      new_round_start;
  logic                      decoder_start;
  logic                      decoder_done;
  logic                      decoder_error;
  logic                      result_valid;
  logic [DURATION_WIDTH-1:0] duration;
  logic                      error_detected;
  logic                      timeout;
  logic                      downstream_busy;
  logic                      start_overrun;

  modport master (
    output new_round_start, decoder_done, decoder_error,
    input  decoder_start, result_valid, duration, error_detected,
           timeout, downstream_busy, start_overrun
  );

  modport slave (
    input  new_round_start, decoder_done, decoder_error,
    output decoder_start, result_valid, duration, error_detected,
           timeout, downstream_busy, start_overrun
  );
endinterface

// File: rtl/round_latency_tracker.sv
// Round latency tracker: launches one decoder run per round request, counts
// cycles until decoder_done (or a MAX_DURATION timeout) and reports the
// result to the round controller, holding downstream_busy while in flight.
// Optional macro ROUND_TIMER_BUCKET_EN: report duration >> BUCKET_SHIFT
// (minimum 1) so coarse histogram bins fit the result memory.
module round_latency_tracker #(
  parameter int DURATION_WIDTH = 32,
  parameter int MAX_DURATION   = 4095,
  parameter int SETTLE_CYCLES  = 4,
  parameter int BUCKET_SHIFT   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  round_latency_tracker_if.slave  bus
);

  localparam int CNT_W    = $clog2(MAX_DURATION + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT    = CNT_W'(MAX_DURATION);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);

  // Reject configurations the counters cannot represent.
  if (MAX_DURATION < 2 || SETTLE_CYCLES < 1 || BUCKET_SHIFT < 0 ||
      CNT_W > DURATION_WIDTH) begin : g_bad_param
    $error("round_latency_tracker: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    REPORT,
    SETTLE
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic [SETTLE_W-1:0]  settle_cnt;

  // Map a raw cycle count onto the reported duration value.
  function automatic logic [DURATION_WIDTH-1:0] scale(input logic [CNT_W-1:0] c);
`ifdef ROUND_TIMER_BUCKET_EN
    logic [CNT_W-1:0] s;
    s = c >> BUCKET_SHIFT;
    if (s == '0 && c != '0) s = CNT_W'(1);
    return DURATION_WIDTH'(s);
`else
    return DURATION_WIDTH'(c);
`endif
  endfunction

  // State register; reset forces IDLE immediately, even mid-round.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.new_round_start) next_state = LAUNCH;
      LAUNCH:  next_state = RUN;
      RUN:     if (bus.decoder_done || cnt == MAX_CNT) next_state = REPORT;
      REPORT:  next_state = SETTLE;
      SETTLE:  if (settle_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, cycle counter and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt                 <= '0;
      settle_cnt          <= '0;
      bus.decoder_start   <= 1'b0;
      bus.result_valid    <= 1'b0;
      bus.duration        <= '0;
      bus.error_detected  <= 1'b0;
      bus.timeout         <= 1'b0;
      bus.downstream_busy <= 1'b0;
      bus.start_overrun   <= 1'b0;
    end else begin
      // LAUNCH is only reachable from IDLE, so this is a single-cycle pulse.
      bus.decoder_start   <= (next_state == LAUNCH);
      bus.downstream_busy <= (next_state != IDLE);

      // Requests arriving while a round is in flight are dropped but noted.
      if (bus.new_round_start && state != IDLE) bus.start_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.new_round_start) begin
            bus.result_valid   <= 1'b0;
            bus.error_detected <= 1'b0;
            bus.timeout        <= 1'b0;
          end
        end
        LAUNCH: begin
          // Done during launch is ignored; counting starts at 1 in RUN.
          cnt <= CNT_W'(1);
        end
        RUN: begin
          if (bus.decoder_done) begin
            // Done wins over a simultaneous limit hit.
            bus.duration       <= scale(cnt);
            bus.error_detected <= bus.decoder_error;
            bus.timeout        <= 1'b0;
          end else if (cnt == MAX_CNT) begin
            bus.duration       <= scale(MAX_CNT);
            bus.error_detected <= 1'b1;
            bus.timeout        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          bus.result_valid <= 1'b1;
          settle_cnt       <= SETTLE_VAL;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_latency_tracker.sv
// Directed self-checking bench for round_latency_tracker (MAX_DURATION=16,
// SETTLE_CYCLES=4, BUCKET_SHIFT=2). Expected durations follow the bucket
// rule when ROUND_TIMER_BUCKET_EN is defined, raw counts otherwise.
module tb_round_latency_tracker;

  localparam int DW     = 32;
  localparam int MAXD   = 16;
  localparam int SETTLE = 4;
  localparam int SHIFT  = 2;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  round_latency_tracker_if #(.DURATION_WIDTH(DW)) bus ();

  round_latency_tracker #(
    .DURATION_WIDTH (DW),
    .MAX_DURATION   (MAXD),
    .SETTLE_CYCLES  (SETTLE),
    .BUCKET_SHIFT   (SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_dur(input int n);
`ifdef ROUND_TIMER_BUCKET_EN
    int s;
    s = n >> SHIFT;
    if (s == 0 && n >= 1) s = 1;
    return 32'(s);
`else
    return 32'(n);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse a start in IDLE; returns one step into RUN (cnt == 1).
  task automatic launch(input string tag, input bit done_in_launch);
    bus.new_round_start = 1'b1;
    cycle();
    bus.new_round_start = 1'b0;
    check({tag, "_dec_start_hi"}, 32'(bus.decoder_start), 32'd1);
    check({tag, "_busy_hi"}, 32'(bus.downstream_busy), 32'd1);
    check({tag, "_rv_cleared"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_err_cleared"}, 32'(bus.error_detected), 32'd0);
    check({tag, "_to_cleared"}, 32'(bus.timeout), 32'd0);
    if (done_in_launch) bus.decoder_done = 1'b1;
    cycle();
    bus.decoder_done = 1'b0;
    check({tag, "_dec_start_lo"}, 32'(bus.decoder_start), 32'd0);
  endtask

  // Bounded wait for the tracker to return to IDLE.
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!bus.downstream_busy) break;
      cycle();
    end
    check({tag, "_idle_reached"}, 32'(bus.downstream_busy), 32'd0);
  endtask

  initial begin
    reset               = 1'b1;
    bus.new_round_start = 1'b0;
    bus.decoder_done    = 1'b0;
    bus.decoder_error   = 1'b0;
    #3;
    check("rst_busy", 32'(bus.downstream_busy), 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    check("rst_dur", bus.duration, 32'd0);
    check("rst_ovr", 32'(bus.start_overrun), 32'd0);
    check("rst_dec_start", 32'(bus.decoder_start), 32'd0);
    cycle(2);
    reset = 1'b0;
    cycle();

    // Round 1: done sampled at cnt=5.
    launch("r1", 1'b0);
    cycle(4);
    bus.decoder_done = 1'b1;
    cycle();
    bus.decoder_done = 1'b0;
    check("r1_dur", bus.duration, exp_dur(5));
    check("r1_err", 32'(bus.error_detected), 32'd0);
    check("r1_rv_not_yet", 32'(bus.result_valid), 32'd0);
    cycle();
    check("r1_rv_rise", 32'(bus.result_valid), 32'd1);
    cycle(SETTLE);
    check("r1_busy_still", 32'(bus.downstream_busy), 32'd1);
    cycle();
    check("r1_busy_fall", 32'(bus.downstream_busy), 32'd0);
    check("r1_rv_held", 32'(bus.result_valid), 32'd1);

    // Round 2: done with error in the first RUN cycle.
    launch("r2", 1'b0);
    bus.decoder_done  = 1'b1;
    bus.decoder_error = 1'b1;
    cycle();
    bus.decoder_done  = 1'b0;
    bus.decoder_error = 1'b0;
    check("r2_dur", bus.duration, exp_dur(1));
    check("r2_err", 32'(bus.error_detected), 32'd1);
    check("r2_to", 32'(bus.timeout), 32'd0);
    wait_idle("r2");

    // Round 3: timeout, with done during LAUNCH and starts in RUN and SETTLE.
    launch("r3", 1'b1);
    check("r3_no_ovr_yet", 32'(bus.start_overrun), 32'd0);
    bus.new_round_start = 1'b1;
    cycle();
    bus.new_round_start = 1'b0;
    check("r3_ovr_run", 32'(bus.start_overrun), 32'd1);
    cycle(14);
    check("r3_to_not_yet", 32'(bus.timeout), 32'd0);
    check("r3_err_not_yet", 32'(bus.error_detected), 32'd0);
    cycle();
    check("r3_to", 32'(bus.timeout), 32'd1);
    check("r3_err", 32'(bus.error_detected), 32'd1);
    check("r3_dur", bus.duration, exp_dur(MAXD));
    cycle();
    check("r3_rv", 32'(bus.result_valid), 32'd1);
    bus.new_round_start = 1'b1;
    cycle();
    bus.new_round_start = 1'b0;
    check("r3_settle_busy", 32'(bus.downstream_busy), 32'd1);
    check("r3_settle_dur", bus.duration, exp_dur(MAXD));
    check("r3_settle_to", 32'(bus.timeout), 32'd1);
    wait_idle("r3");
    check("r3_rv_idle", 32'(bus.result_valid), 32'd1);
    check("r3_ovr_sticky", 32'(bus.start_overrun), 32'd1);

    // Round 4: reset while RUN at cnt=7.
    launch("r4", 1'b0);
    cycle(6);
    reset = 1'b1;
    #1;
    check("r4_rst_busy", 32'(bus.downstream_busy), 32'd0);
    check("r4_rst_rv", 32'(bus.result_valid), 32'd0);
    check("r4_rst_dur", bus.duration, 32'd0);
    check("r4_rst_ovr", 32'(bus.start_overrun), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // Round 5: reset during LAUNCH drops decoder_start at once.
    bus.new_round_start = 1'b1;
    cycle();
    bus.new_round_start = 1'b0;
    check("r5_dec_start_hi", 32'(bus.decoder_start), 32'd1);
    reset = 1'b1;
    #1;
    check("r5_rst_dec_start", 32'(bus.decoder_start), 32'd0);
    check("r5_rst_busy", 32'(bus.downstream_busy), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // Round 6: first round after reset, done at cnt=13.
    launch("r6", 1'b0);
    cycle(12);
    bus.decoder_done = 1'b1;
    cycle();
    bus.decoder_done = 1'b0;
    check("r6_dur", bus.duration, exp_dur(13));
    check("r6_to", 32'(bus.timeout), 32'd0);
    wait_idle("r6");

    // Round 7: done at cnt=2.
    launch("r7", 1'b0);
    cycle(1);
    bus.decoder_done = 1'b1;
    cycle();
    bus.decoder_done = 1'b0;
    check("r7_dur", bus.duration, exp_dur(2));
    wait_idle("r7");

    // Round 8: done exactly at the limit wins over timeout.
    launch("r8", 1'b0);
    cycle(15);
    bus.decoder_done = 1'b1;
    cycle();
    bus.decoder_done = 1'b0;
    check("r8_dur", bus.duration, exp_dur(MAXD));
    check("r8_to", 32'(bus.timeout), 32'd0);
    check("r8_err", 32'(bus.error_detected), 32'd0);
    wait_idle("r8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
